// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 sensor responder (and its host).
//   - FSM state encoding
//   - bit offsets of each byte inside the 40-bit frame (MSB transmitted first)
//   - datasheet timing defaults, in 1 us clock cycles
//   - build_frame(): assembles the 40-bit frame including checksum
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_WAIT_REL,
    ST_RESP_LO,
    ST_RESP_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_END_LO
  } dht_state_e;

  localparam int FRAME_W        = 40;
  localparam int HUM_INT_LSB    = 32;
  localparam int HUM_FLOAT_LSB  = 24;
  localparam int TEMP_INT_LSB   = 16;
  localparam int TEMP_FLOAT_LSB = 8;
  localparam int CHECKSUM_LSB   = 0;

  localparam int DEF_START_MIN_LOW = 18000;
  localparam int DEF_RESP_DELAY    = 30;
  localparam int DEF_RESP_LOW      = 80;
  localparam int DEF_RESP_HIGH     = 80;
  localparam int DEF_BIT_LOW       = 50;
  localparam int DEF_BIT0_HIGH     = 27;
  localparam int DEF_BIT1_HIGH     = 70;
  localparam int DEF_END_LOW       = 50;
  localparam int DEF_CNT_W         = 15;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_float;
    logic [7:0] temp_int;
    logic [7:0] temp_float;
  } dht_bytes_t;

  // Checksum is the 8-bit wrap-around sum of the four data bytes; bad_cks
  // flips its LSB to let a host exercise its checksum-error path.
  function automatic logic [FRAME_W-1:0] build_frame(input dht_bytes_t b,
                                                     input logic bad_cks);
    logic [FRAME_W-1:0] f;
    logic [7:0]         cks;
    cks    = b.hum_int + b.hum_float + b.temp_int + b.temp_float;
    cks[0] = cks[0] ^ bad_cks;
    f      = '0;
    f[HUM_INT_LSB    +: 8] = b.hum_int;
    f[HUM_FLOAT_LSB  +: 8] = b.hum_float;
    f[TEMP_INT_LSB   +: 8] = b.temp_int;
    f[TEMP_FLOAT_LSB +: 8] = b.temp_float;
    f[CHECKSUM_LSB   +: 8] = cks;
    return f;
  endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// Control/status interface of the DHT11 responder.
//   master: data source / test controller (drives bytes, load, fault injection)
//   slave : the responder (reports busy, start_detected, frame_done)
interface dht11_responder_if;
  logic       load;
  logic [7:0] hum_int;
  logic [7:0] hum_float;
  logic [7:0] temp_int;
  logic [7:0] temp_float;
  logic       force_bad_checksum;
  logic       no_response;
  logic       busy;
  logic       start_detected;
  logic       frame_done;

  modport master (
    output load, hum_int, hum_float, temp_int, temp_float,
           force_bad_checksum, no_response,
    input  busy, start_detected, frame_done
  );

  modport slave (
    input  load, hum_int, hum_float, temp_int, temp_float,
           force_bad_checksum, no_response,
    output busy, start_detected, frame_done
  );
endinterface

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the asynchronous single-wire bus.
//   clk, rst : clock, async active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized output (2 cycles latency)
// Resets to RST_VAL; the idle bus level (1) keeps reset from looking like
// a host start pulse.
module dht11_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/tristate_cell.sv
// Pad tristate buffer: drives d_i onto pad_io while en_i, else high-Z.
//   en_i   : output enable
//   d_i    : value driven when enabled
//   pad_io : pad net
module tristate_cell (
  input  logic en_i,
  input  logic d_i,
  inout  wire  pad_io
);
  assign pad_io = en_i ? d_i : 1'bz;
endmodule

// File: rtl/dht11_responder.sv
// Sensor-side DHT11 emulator. Waits for a host start pulse on the single
// wire bus, answers with the response preamble and serializes a 40-bit frame
// (hum_int, hum_float, temp_int, temp_float, checksum), MSB first.
//   clk      : 1 us clock          rst : async active-high reset
//   dht_data : open-drain bus, only ever driven 0 or released
//   ctrl     : load/bytes/fault-injection in, busy/start_detected/frame_done out
// All durations are in clk cycles and hold exactly at the pin because the
// pin enable is a pure decode of the state register and the timer restarts
// on every state entry.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int START_MIN_LOW = DEF_START_MIN_LOW,
  parameter int RESP_DELAY    = DEF_RESP_DELAY,
  parameter int RESP_LOW      = DEF_RESP_LOW,
  parameter int RESP_HIGH     = DEF_RESP_HIGH,
  parameter int BIT_LOW       = DEF_BIT_LOW,
  parameter int BIT0_HIGH     = DEF_BIT0_HIGH,
  parameter int BIT1_HIGH     = DEF_BIT1_HIGH,
  parameter int END_LOW       = DEF_END_LOW,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire              dht_data,
  dht11_responder_if.slave ctrl
);
  // Terminal counts: a state lasting N cycles exits when timer == N-1.
  localparam logic [CNT_W-1:0] T_START = CNT_W'(START_MIN_LOW - 1);
  localparam logic [CNT_W-1:0] T_DELAY = CNT_W'(RESP_DELAY - 1);
  localparam logic [CNT_W-1:0] T_RLOW  = CNT_W'(RESP_LOW - 1);
  localparam logic [CNT_W-1:0] T_RHIGH = CNT_W'(RESP_HIGH - 1);
  localparam logic [CNT_W-1:0] T_BLOW  = CNT_W'(BIT_LOW - 1);
  localparam logic [CNT_W-1:0] T_B0    = CNT_W'(BIT0_HIGH - 1);
  localparam logic [CNT_W-1:0] T_B1    = CNT_W'(BIT1_HIGH - 1);
  localparam logic [CNT_W-1:0] T_ELOW  = CNT_W'(END_LOW - 1);

  dht_state_e         state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [5:0]         bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  dht_bytes_t         shadow_q;
  logic               nores_q, nores_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               bus_s;
  logic               drive_low;

  dht11_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (dht_data),
    .q_o (bus_s)
  );

  // Async reset clears state_q, so the pad releases within the reset cycle.
  assign drive_low = (state_q == ST_RESP_LO) || (state_q == ST_BIT_LO) ||
                     (state_q == ST_END_LO);

  tristate_cell u_pad (
    .en_i   (drive_low),
    .d_i    (1'b0),
    .pad_io (dht_data)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    nores_d   = nores_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      // Our own trailing low echoes through the synchronizer for two cycles
      // after END_LO; it lands here and is rejected as a glitch.
      ST_IDLE: if (!bus_s) state_d = ST_HOST_LOW;
      ST_HOST_LOW: begin
        if (bus_s) begin
          if (timer_q >= T_START) begin
            frame_d = build_frame(shadow_q, ctrl.force_bad_checksum);
            nores_d = ctrl.no_response;
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_WAIT_REL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_REL: begin
        if (nores_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (timer_q == T_DELAY) begin
          state_d = ST_RESP_LO;
        end
      end
      ST_RESP_LO: if (timer_q == T_RLOW) state_d = ST_RESP_HI;
      ST_RESP_HI: begin
        if (timer_q == T_RHIGH) begin
          state_d   = ST_BIT_LO;
          bit_idx_d = 6'd39;
        end
      end
      ST_BIT_LO: if (timer_q == T_BLOW) state_d = ST_BIT_HI;
      ST_BIT_HI: begin
        if (timer_q == (frame_q[bit_idx_q] ? T_B1 : T_B0)) begin
          if (bit_idx_q == 6'd0) begin
            state_d = ST_END_LO;
          end else begin
            bit_idx_d = bit_idx_q - 6'd1;
            state_d   = ST_BIT_LO;
          end
        end
      end
      ST_END_LO: begin
        if (timer_q == T_ELOW) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state entry and saturates otherwise, so a host
    // holding the line low forever cannot wrap it back under START_MIN_LOW.
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      shadow_q  <= '0;
      nores_q   <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      nores_q   <= nores_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      done_q    <= done_d;
      // Shadow feeds only the next snapshot; the frame in flight is frame_q.
      if (ctrl.load)
        shadow_q <= {ctrl.hum_int, ctrl.hum_float, ctrl.temp_int, ctrl.temp_float};
    end
  end

  assign ctrl.busy           = busy_q;
  assign ctrl.start_detected = start_q;
  assign ctrl.frame_done     = done_q;
endmodule
